// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch pins in, debounced levels and edge pulses out
interface switch_debouncer_if #(
  parameter int NUM_SW = 2
);
  logic [NUM_SW-1:0] i_switch;
  logic [NUM_SW-1:0] o_switch;
  logic [NUM_SW-1:0] o_rise;
  logic [NUM_SW-1:0] o_fall;
  modport master (output i_switch, input o_switch, input o_rise, input o_fall);
  modport slave (input i_switch, output o_switch, output o_rise, output o_fall);
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-channel 2-flop synchronizer, settle counter and FSM producing clean levels and edge pulses
module switch_debouncer #(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic            i_clk,
  input logic            i_reset,
  switch_debouncer_if.slave sw
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {STABLE, SETTLING} state_t;
  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    logic          r_sync1, r_sync2, r_sw, r_rise, r_fall;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_sw    <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_cnt   <= '0;
        r_state <= STABLE;
      end else begin
        r_sync1 <= sw.i_switch[g];
        r_sync2 <= r_sync1;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_cnt   <= '0;
        if (r_state == STABLE) begin
          r_state <= (r_sync2 != r_sw) ? SETTLING : STABLE;
        end else if (r_sync2 == r_sw) begin
          r_state <= STABLE;
        end else if (r_cnt == LAST) begin
          // sync2 differs from the accepted level here, so the new level alone picks the pulse
          r_sw    <= r_sync2;
          r_rise  <= r_sync2;
          r_fall  <= ~r_sync2;
          r_state <= STABLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
    assign sw.o_switch[g] = r_sw;
    assign sw.o_rise[g]   = r_rise;
    assign sw.o_fall[g]   = r_fall;
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed vectors for switch_debouncer with DEBOUNCE_CYCLES=4 (7-edge latency)
module tb_switch_debouncer;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  switch_debouncer_if #(.NUM_SW(2)) sw ();
  switch_debouncer #(.NUM_SW(2), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .sw     (sw)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic [1:0] in;
    logic [1:0] old_sw;
    logic [1:0] new_sw;
    logic [1:0] rise;
    logic [1:0] fall;
  } phase_t;
  phase_t ph[5];
  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {sw.o_switch, sw.o_rise, sw.o_fall};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: sw/rise/fall got %b_%b_%b expected %b_%b_%b",
                  name, got[5:4], got[3:2], got[1:0], exp[5:4], exp[3:2], exp[1:0]);
  endtask
  task automatic step(input logic [1:0] in);
    sw.i_switch = in;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask
  initial begin
    ph[0] = '{in: 2'b01, old_sw: 2'b00, new_sw: 2'b01, rise: 2'b01, fall: 2'b00};
    ph[1] = '{in: 2'b00, old_sw: 2'b01, new_sw: 2'b00, rise: 2'b00, fall: 2'b01};
    ph[2] = '{in: 2'b10, old_sw: 2'b00, new_sw: 2'b10, rise: 2'b10, fall: 2'b00};
    ph[3] = '{in: 2'b01, old_sw: 2'b10, new_sw: 2'b01, rise: 2'b01, fall: 2'b10};
    ph[4] = '{in: 2'b00, old_sw: 2'b01, new_sw: 2'b00, rise: 2'b00, fall: 2'b01};
    sw.i_switch = 2'b00;
    #2 i_reset = 1'b1;
    #1 chk("reset_state", 6'b0);
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("reset_hold", 6'b0);
    // clean rise/fall and simultaneous opposite-direction changes
    for (int i = 0; i < 5; i++)
      for (int s = 1; s <= 8; s++) begin
        step(ph[i].in);
        chk($sformatf("phase%0d_edge%0d", i, s),
            s < 7 ? {ph[i].old_sw, 4'b0} :
            s == 7 ? {ph[i].new_sw, ph[i].rise, ph[i].fall} : {ph[i].new_sw, 4'b0});
      end
    // 3-cycle glitch on ch0 must be rejected
    for (int s = 1; s <= 20; s++) begin
      step(s <= 3 ? 2'b01 : 2'b00);
      chk($sformatf("glitch_c%0d", s), 6'b0);
    end
    // ch1 bounces every 2 cycles, then holds high
    for (int s = 0; s < 12; s++) begin
      step((s % 4) < 2 ? 2'b10 : 2'b00);
      chk($sformatf("bounce_c%0d", s), 6'b0);
    end
    for (int s = 1; s <= 8; s++) begin
      step(2'b10);
      chk($sformatf("settle_edge%0d", s),
          s < 7 ? 6'b0 : s == 7 ? 6'b10_10_00 : 6'b10_00_00);
    end
    for (int s = 1; s <= 8; s++) begin
      step(2'b00);
      chk($sformatf("release_edge%0d", s),
          s < 7 ? 6'b10_00_00 : s == 7 ? 6'b00_00_10 : 6'b0);
    end
    // async reset between edges from o_switch=11
    for (int s = 1; s <= 8; s++) step(2'b11);
    chk("both_high", 6'b11_00_00);
    #2 i_reset = 1'b1;
    #1 chk("async_reset_immediate", 6'b0);
    for (int s = 1; s <= 3; s++) begin
      step(2'b11);
      chk($sformatf("reset_held_edge%0d", s), 6'b0);
    end
    sw.i_switch = 2'b00;
    i_reset = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step(2'b00);
      chk($sformatf("post_reset_quiet%0d", s), 6'b0);
    end
    // reset pulsed at edge 5 of a pending ch0 rise
    for (int s = 1; s <= 4; s++) begin
      step(2'b01);
      chk($sformatf("pre_reset_edge%0d", s), 6'b0);
    end
    i_reset = 1'b1;
    step(2'b01);
    chk("mid_settle_reset", 6'b0);
    i_reset = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step(2'b01);
      chk($sformatf("after_reset_edge%0d", s),
          s < 7 ? 6'b0 : s == 7 ? 6'b01_01_00 : 6'b01_00_00);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions raw, asynchronous, mechanically bouncing slide-switch inputs into clean, clock-synchronous levels and single-cycle edge pulses. It is the input-side counterpart of the board's combinational gate logic: the gates consume switch levels, and this block produces those levels glitch-free from the physical pins. Each switch channel has its own synchronizer, settle counter and two-state FSM, and all channels share one clock and reset.

## Interface
Parameters:
- NUM_SW, 2: number of independent switch channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range ≥ 2.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_switch  input  NUM_SW  raw switch pins, asynchronous to i_clk.
- o_switch  output  NUM_SW  debounced switch levels.
- o_rise  output  NUM_SW  one-cycle pulse per channel when o_switch goes 0→1.
- o_fall  output  NUM_SW  one-cycle pulse per channel when o_switch goes 1→0.

Clocking and reset: one clock (i_clk); reset (i_reset) is asynchronous and active-high.

## Operation
- Per channel, a two-flop synchronizer runs i_switch → sync1 → sync2. Only sync2 is used downstream.
- The settle counter is $clog2(DEBOUNCE_CYCLES) bits wide and unsigned. It never wraps, because it is cleared before reaching DEBOUNCE_CYCLES.
- Each channel has an FSM with two states: STABLE and SETTLING.
- In STABLE:
  - If sync2 ≠ o_switch, go to SETTLING and set the counter to 0.
  - Otherwise stay in STABLE with the counter at 0.
- In SETTLING:
  - If sync2 = o_switch (a bounce back to the accepted level), go to STABLE and clear the counter. o_switch does not change and no pulse is issued.
  - Else if counter = DEBOUNCE_CYCLES−1, load o_switch with sync2, assert o_rise or o_fall according to the new level, clear the counter, and go to STABLE.
  - Else increment the counter.
- o_rise and o_fall are registered. Each is high for exactly one cycle, in the same cycle o_switch takes its new value.
- For a given channel, o_rise and o_fall are never high together.
- Channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle on each channel's own bit.

## Timing
- Reset values: o_switch = 0, o_rise = 0, o_fall = 0. Synchronizers and counters are 0 and every FSM is in STABLE.
- Reset takes effect immediately and asynchronously, including mid-settle: any pending settle is discarded and no pulse is emitted.
- Latency: take the first rising edge at which sync1 samples the new pin level as edge 1. If the pin stays constant, o_switch and the pulse update at edge DEBOUNCE_CYCLES+3.
- Any return of sync2 to the accepted level restarts the qualification. The full latency then applies again, measured from the last pin transition.
- If the pin is high when reset releases, this is a genuine 0→1 change: o_switch rises after the full latency, with one o_rise pulse.
- No pulse is issued while in STABLE. A level that repeats the accepted value generates nothing.

## Test plan
All scenarios use NUM_SW=2 and DEBOUNCE_CYCLES=4, so the latency is 7 edges.
- **Async reset:** set i_switch=11 and let the outputs settle high, then assert i_reset between clock edges → o_switch=00, o_rise=00, o_fall=00 before the next edge. Hold reset for 3 edges → outputs stay 0.
- **Clean rise:** i_switch goes 00→01, sampled at edge 1 → o_switch=01 and o_rise=01 at edge 7, o_rise=00 at edge 8, o_fall=00 throughout. Then return to 00 → o_switch=00 with one o_fall=01 pulse 7 edges later.
- **Short glitch:** ch0 high for exactly 3 clock cycles, then low → o_switch stays 00 and no pulses occur over 20 cycles.
- **Bounce then settle:** ch1 toggles every 2 cycles for 12 cycles, then holds 1 → exactly one o_rise=10 pulse, 7 edges after the last pin transition. No o_fall pulses.
- **Simultaneous channels:** from o_switch=10, change i_switch to 01 on one edge → at edge 7, o_switch=01, o_rise=01 and o_fall=10 in the same cycle, each lasting one cycle.
- **Reset mid-settle:** ch0 goes high, and i_reset is pulsed at edge 5, before acceptance. Input stays high → no pulse before reset. After release, o_switch[0] rises with one o_rise pulse exactly 7 edges after the first post-reset sampling edge.
